// File: rtl/controlador_motores_n.sv
`timescale 1ns/1ps
// Purpose : N-motor enable sequencer: one-hot rotation (alternating) or cumulative staggered start.
// Latency : start and stop act on the same CLK edge that samples ARRANQUE; MOTOR/OCUPADO are registered.
// Backpr. : none; ARRANQUE is a level request. It is ignored while a soft stop is in progress.
//
// Ports:
//   CLK      in   rising-edge clock
//   REINICIO in   asynchronous active-high reset
//   ARRANQUE in   run request (level)
//   MODO     in   0 = alternating, 1 = staggered all-on (latched at start)
//   MOTOR    out  [N_MOTORES-1:0] motor enables
//   OCUPADO  out  high whenever the sequencer is not idle
// Build option: define PARADA_SUAVE_EN for the soft stop (motors released one by one,
// highest first). Without it every stop clears all motors on the stop edge.
module controlador_motores_n #(
   parameter int N_MOTORES      = 2,
   parameter int CICLOS_TURNO   = 4,
   parameter int CICLOS_ESCALON = 2
) (
   input  logic                 CLK,
   input  logic                 REINICIO,
   input  logic                 ARRANQUE,
   input  logic                 MODO,
   output logic [N_MOTORES-1:0] MOTOR,
   output logic                 OCUPADO
);

   typedef enum logic [2:0] {
      REPOSO,
      ALTERNAR,
      ESCALONAR,
      TODOS,
      PARADA
   } estado_t;

   // Terminal counts: the counter runs 0..FIN, so a bit holds for FIN+1 cycles.
   localparam logic [7:0] TURNO_FIN   = 8'(CICLOS_TURNO - 1);
   localparam logic [7:0] ESCALON_FIN = 8'(CICLOS_ESCALON - 1);
   localparam logic [N_MOTORES-1:0] MOTOR_TODOS = '1;
   localparam logic [N_MOTORES-1:0] MOTOR_UNO   = {{(N_MOTORES-1){1'b0}}, 1'b1};

   estado_t                estado_q, estado_d;
   logic [N_MOTORES-1:0]   motor_q, motor_d;
   logic [7:0]             cnt_q, cnt_d;
   logic                   modo_q, modo_d;
   logic                   ocupado_q, ocupado_d;

   always_ff @(posedge CLK or posedge REINICIO) begin
      if (REINICIO) begin
         estado_q  <= REPOSO;
         motor_q   <= '0;
         cnt_q     <= '0;
         modo_q    <= 1'b0;
         ocupado_q <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         motor_q   <= motor_d;
         cnt_q     <= cnt_d;
         modo_q    <= modo_d;
         ocupado_q <= ocupado_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      motor_d  = motor_q;
      cnt_d    = cnt_q;
      modo_d   = modo_q;

      case (estado_q)
         REPOSO: begin
            motor_d = '0;
            cnt_d   = '0;
            if (ARRANQUE) begin
               modo_d   = MODO;
               motor_d  = MOTOR_UNO;
               estado_d = MODO ? ESCALONAR : ALTERNAR;
            end
         end

         ALTERNAR, ESCALONAR, TODOS: begin
            if (!ARRANQUE) begin
               cnt_d = '0;
`ifdef PARADA_SUAVE_EN
               if (modo_q) begin
                  // Enabled bits are always a contiguous run from bit 0,
                  // so dropping the highest one is a right shift.
                  motor_d  = motor_q >> 1;
                  estado_d = ((motor_q >> 1) == '0) ? REPOSO : PARADA;
               end else begin
                  motor_d  = '0;
                  estado_d = REPOSO;
               end
`else
               motor_d  = '0;
               estado_d = REPOSO;
`endif
            end else if (!modo_q) begin
               if (cnt_q == TURNO_FIN) begin
                  motor_d = {motor_q[N_MOTORES-2:0], motor_q[N_MOTORES-1]};
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end else if (estado_q == ESCALONAR) begin
               if (cnt_q == ESCALON_FIN) begin
                  motor_d = {motor_q[N_MOTORES-2:0], 1'b1};
                  cnt_d   = '0;
                  if ({motor_q[N_MOTORES-2:0], 1'b1} == MOTOR_TODOS)
                     estado_d = TODOS;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            // TODOS with ARRANQUE high: hold all ones, counter idle.
         end

         PARADA: begin
`ifdef PARADA_SUAVE_EN
            // ARRANQUE deliberately not examined: a soft stop always completes.
            if (cnt_q == ESCALON_FIN) begin
               motor_d = motor_q >> 1;
               cnt_d   = '0;
               if ((motor_q >> 1) == '0)
                  estado_d = REPOSO;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`else
            motor_d  = '0;
            cnt_d    = '0;
            estado_d = REPOSO;
`endif
         end

         default: begin
            motor_d  = '0;
            cnt_d    = '0;
            estado_d = REPOSO;
         end
      endcase

      ocupado_d = (estado_d != REPOSO);
   end

   assign MOTOR   = motor_q;
   assign OCUPADO = ocupado_q;

endmodule
